// File: rtl/sram_ctl.sv
// sram_ctl: request-side controller in front of the registered-pin SRAM array.
// Accepts single-beat writes and 1..16-beat burst reads on a valid/ready
// request channel, drives the array's registered address/data/write-enable
// pins, follows the array's two-edge read latency and returns read data
// through a 4-entry response FIFO.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/req_ready      request handshake
//   req_we                   1 = write, 0 = burst read
//   req_addr[22:0]           start address ([22:18] chip, [17:0] word)
//   req_len[3:0]             read beats minus one (ignored for writes)
//   req_wdata[63:0]          write data
//   rsp_valid/rsp_ready      response handshake (FIFO head)
//   rsp_rdata[63:0]          FIFO head data
//   mem_addr/mem_wdata/mem_we  registered pins to the array
//   mem_rdata[63:0]          registered read data from the array
//   busy                     any request, beat or response still in flight
module sram_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [22:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic [22:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_we,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {IDLE, READ} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  beats_left;
  logic        s1;
  logic        s2;
  logic [63:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  fifo_count;
  logic        credit_ok;
  logic        issue;
  logic        wr_acc;
  logic        rd_acc;
  logic        push;
  logic        pop;

  // Beats already in the array pipeline still need a FIFO slot, so they
  // count against the credit; a pop on this same edge does not.
  assign credit_ok = ({1'b0, fifo_count} + {3'd0, s1} + {3'd0, s2}) < 4'd4;

  assign wr_acc = req_valid && req_ready && req_we;
  assign rd_acc = req_valid && req_ready && !req_we;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_acc && (req_len != 4'd0)) state_nxt = READ;
      READ:    if (issue && (beats_left == 4'd1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE:    req_ready = req_we || credit_ok;
      READ:    issue     = credit_ok;
      default: ;
    endcase
  end

  // Issue stage: array pins and beat-0 / follow-on beat launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      beats_left <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
    end else begin
      mem_we <= wr_acc;
      s1     <= rd_acc || issue;
      s2     <= s1;
      if (wr_acc) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end else if (rd_acc) begin
        mem_addr   <= req_addr;
        beats_left <= req_len;
      end else if (issue) begin
        // 23-bit wrap carries the burst across chip selects
        mem_addr   <= mem_addr + 23'd1;
        beats_left <= beats_left - 4'd1;
      end
    end
  end

  // Response stage: s2 marks array output belonging to an issued beat
  assign push = s2;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  assign rsp_valid = (fifo_count != 3'd0);
  // Storage is not reset; an empty FIFO presents zero data.
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : 64'd0;

  assign busy = (state != IDLE) || mem_we || s1 || s2 || (fifo_count != 3'd0);

endmodule

// File: tb/tb_sram_ctl.sv
// Directed bench for sram_ctl with a behavioural registered-pin array model
// and a response scoreboard.
module tb_sram_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [22:0] req_addr;
  logic [3:0]  req_len;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic [22:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic [63:0] mem_rdata = 64'd0;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int max_cnt = 0;

  logic [63:0] exp_q [$];
  logic [63:0] ref_mem [logic [22:0]];
  logic [63:0] arr_mem [logic [22:0]];

  sram_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Array: registered address/data/we, registered read data, read-before-write.
  always @(posedge clk) begin
    mem_rdata <= arr_mem.exists(mem_addr) ? arr_mem[mem_addr] : 64'd0;
    if (mem_we) arr_mem[mem_addr] = mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: compares each popped beat against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("fifo_bound", 64'(dut.fifo_count <= 3'd4), 64'd1);
      if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("rsp_data", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [22:0] a, input logic [3:0] l,
                        input logic [63:0] d);
    int n;
    logic [22:0] ba;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_len   = l;
    req_wdata = d;
    #1;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    if (we) begin
      ref_mem[a] = d;
    end else begin
      for (int i = 0; i <= int'(l); i++) begin
        ba = a + 23'(i);
        exp_q.push_back(ref_mem.exists(ba) ? ref_mem[ba] : 64'd0);
      end
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int rdy_low;
    int run;
    int best;
    int tot;
    int seen;
    int n;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_mem_addr",  64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_we",    64'(mem_we), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();

    // Single write then read, 2-edge latency
    do_req(1'b1, 23'h000023, 4'd0, 64'hDEAD_BEEF_0000_0001);
    do_req(1'b0, 23'h000023, 4'd0, 64'd0);
    check("lat_e1_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("lat_e1b_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("lat_e2_valid", 64'(rsp_valid), 64'd1);
    check("lat_e2_data", rsp_rdata, 64'hDEAD_BEEF_0000_0001);
    tick();
    check("lat_e3_valid", 64'(rsp_valid), 64'd0);
    drain();

    // Full-throughput 16-beat burst
    for (int i = 0; i < 16; i++) do_req(1'b1, 23'(i), 4'd0, 64'(i));
    do_req(1'b0, 23'd0, 4'd15, 64'd0);
    rdy_low = 0; run = 0; best = 0; tot = 0;
    for (int k = 0; k < 30; k++) begin
      if (!req_ready) rdy_low++;
      if (rsp_valid) begin
        run++;
        tot++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      tick();
    end
    check("burst_req_ready_low", 64'(rdy_low), 64'd15);
    check("burst_consecutive", 64'(best), 64'd16);
    check("burst_total", 64'(tot), 64'd16);
    drain();

    // Backpressure: four beats issued, then stall until pops free credit
    rsp_ready = 1'b0;
    max_cnt = 0;
    do_req(1'b0, 23'd0, 4'd15, 64'd0);
    repeat (20) tick();
    check("bp_fifo_max", 64'(max_cnt), 64'd4);
    check("bp_stall_addr", 64'(mem_addr), 64'd3);
    check("bp_none_popped", 64'(exp_q.size()), 64'd16);
    check("bp_busy", 64'(busy), 64'd1);
    rsp_ready = 1'b1;
    drain();

    // Address wrap across 7FFFFF -> 000000
    do_req(1'b1, 23'h7FFFFF, 4'd0, 64'hAAAA_0000_1111_2222);
    do_req(1'b1, 23'h000000, 4'd0, 64'hBBBB_3333_4444_5555);
    do_req(1'b0, 23'h7FFFFF, 4'd1, 64'd0);
    drain();
    check("wrap_mem_addr", 64'(mem_addr), 64'd0);

    // Write / read / write interleave on one address
    do_req(1'b1, 23'd5, 4'd0, 64'h0123_4567_89AB_CDEF);
    do_req(1'b0, 23'd5, 4'd0, 64'd0);
    do_req(1'b1, 23'd5, 4'd0, 64'hFEDC_BA98_7654_3210);
    do_req(1'b0, 23'd5, 4'd0, 64'd0);
    drain();

    // Async reset mid-burst with two beats buffered
    for (int i = 0; i < 8; i++) do_req(1'b1, 23'h100 + 23'(i), 4'd0, 64'h5A00 + 64'(i));
    rsp_ready = 1'b0;
    do_req(1'b0, 23'h100, 4'd7, 64'd0);
    n = 0;
    while (dut.fifo_count != 3'd2 && n < 50) begin
      tick();
      n++;
    end
    check("rstmid_fifo_two", 64'(dut.fifo_count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstmid_rsp_rdata", rsp_rdata, 64'd0);
    check("rstmid_mem_addr",  64'(mem_addr), 64'd0);
    check("rstmid_mem_we",    64'(mem_we), 64'd0);
    check("rstmid_busy",      64'(busy), 64'd0);
    check("rstmid_req_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("rstmid_no_rsp", 64'(seen), 64'd0);
    do_req(1'b0, 23'h103, 4'd0, 64'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
